// File: rtl/req_serializer.sv
// req_serializer: queues parallel {addr, data} write commands and emits each
// one as two AXI-Stream beats (address beat, then data beat) sharing a tid.
module req_serializer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid_i,
  input  logic [18:0]                  cmd_addr_i,
  input  logic [15:0]                  cmd_data_i,
  output logic                         cmd_ready_o,
  output logic                         req_tvalid_o,
  output logic [2:0]                   req_tid_o,
  output logic [15:0]                  req_tdata_o,
  output logic                         req_tlast_o,
  input  logic                         req_tready_i,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level_o,
  output logic [CNT_W-1:0]             cmd_count_o
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  // Entry layout: [34:16] device address, [15:0] write data.
  logic [34:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [34:0]       hold_q;
  state_t            state_q;
  logic              tvalid_q, tlast_q;
  logic [2:0]        tid_q;
  logic [15:0]       tdata_q;
  logic [CNT_W-1:0]  count_q;

  logic              full, empty, push, pop;
  logic [34:0]       head;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign head  = mem_q[rd_ptr_q];
  // Ready comes only from the occupancy register, so a pop cannot open it
  // in the same cycle.
  assign push  = cmd_valid_i & ~full;
  // Pop when idle, or when the current data beat completes (back-to-back).
  assign pop   = ~empty & ((state_q == IDLE) | ((state_q == DATA) & req_tready_i));

  // Occupancy next-state: simultaneous push and pop cancel out.
  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
  end

  // Command storage; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_addr_i, cmd_data_i};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  // Holding register captures the FIFO head whenever a command is popped.
  always_ff @(posedge clk) begin
    if (pop) hold_q <= head;
  end

  // Serializer FSM with registered AXI-Stream outputs and completion counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tid_q    <= '0;
      tdata_q  <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q  <= ADDR;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tdata_q  <= head[34:19];
            tid_q    <= head[18:16];
          end
        end
        ADDR: begin
          if (req_tready_i) begin
            state_q <= DATA;
            tlast_q <= 1'b1;
            tdata_q <= hold_q[15:0];
          end
        end
        DATA: begin
          if (req_tready_i) begin
            count_q <= count_q + CNT_W'(1);
            if (pop) begin
              state_q <= ADDR;
              tlast_q <= 1'b0;
              tdata_q <= head[34:19];
              tid_q   <= head[18:16];
            end else begin
              state_q  <= IDLE;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o  = ~full;
  assign req_tvalid_o = tvalid_q;
  assign req_tid_o    = tid_q;
  assign req_tdata_o  = tdata_q;
  assign req_tlast_o  = tlast_q;
  assign fifo_level_o = level_q;
  assign cmd_count_o  = count_q;

endmodule

// File: tb/tb_req_serializer.sv
// Bench for req_serializer: directed scenarios plus random traffic, checked
// against a beat-queue model of the two-beat serialization.
module tb_req_serializer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid_i;
  logic [18:0] cmd_addr_i;
  logic [15:0] cmd_data_i;
  logic        cmd_ready_o;
  logic        req_tvalid_o;
  logic [2:0]  req_tid_o;
  logic [15:0] req_tdata_o;
  logic        req_tlast_o;
  logic        req_tready_i;
  logic [2:0]  fifo_level_o;
  logic [CNT_W-1:0] cmd_count_o;

  req_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_data_i   (cmd_data_i),
    .cmd_ready_o  (cmd_ready_o),
    .req_tvalid_o (req_tvalid_o),
    .req_tid_o    (req_tid_o),
    .req_tdata_o  (req_tdata_o),
    .req_tlast_o  (req_tlast_o),
    .req_tready_i (req_tready_i),
    .fifo_level_o (fifo_level_o),
    .cmd_count_o  (cmd_count_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: expected beats as {tid, tdata, tlast}; completed commands mod 2^CNT_W.
  logic [19:0]      exp_q[$];
  logic [CNT_W-1:0] exp_count;
  logic             stall_prev;
  logic [20:0]      saved;
  logic             last_acc, last_hs, last_tlast;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: evaluate the handshakes that the coming edge will perform,
  // update the model, then advance to just after the edge.
  task automatic tick();
    logic [19:0] b;
    @(negedge clk);
    last_acc = 1'b0;
    last_hs = 1'b0;
    last_tlast = 1'b0;
    if (reset) begin
      exp_q.delete();
      exp_count = '0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("stable", {req_tvalid_o, req_tid_o, req_tdata_o, req_tlast_o}, saved);
      chk("count", cmd_count_o, exp_count);
      if (cmd_valid_i && cmd_ready_o) begin
        last_acc = 1'b1;
        exp_q.push_back({cmd_addr_i[2:0], cmd_addr_i[18:3], 1'b0});
        exp_q.push_back({cmd_addr_i[2:0], cmd_data_i, 1'b1});
      end
      if (req_tvalid_o && req_tready_i) begin
        last_hs = 1'b1;
        last_tlast = req_tlast_o;
        chk("beat_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          chk("beat", {req_tid_o, req_tdata_o, req_tlast_o}, b);
          if (b[0]) exp_count = exp_count + 1'b1;
        end
      end
      stall_prev = req_tvalid_o & ~req_tready_i;
      saved = {req_tvalid_o, req_tid_o, req_tdata_o, req_tlast_o};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid_i = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Offer n random commands, each held until accepted (bounded).
  task automatic send_n(input int n);
    int idx = 0;
    logic [18:0] ca = 19'($urandom);
    logic [15:0] cd = 16'($urandom);
    for (int c = 0; c < 8 * n + 40 && idx < n; c++) begin
      cmd_valid_i = 1'b1;
      cmd_addr_i = ca;
      cmd_data_i = cd;
      tick();
      if (last_acc) begin
        idx++;
        ca = 19'($urandom);
        cd = 16'($urandom);
      end
    end
    cmd_valid_i = 1'b0;
    chk("send_done", idx, n);
  endtask

  task automatic drain();
    cmd_valid_i = 1'b0;
    req_tready_i = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (exp_q.size() == 0 && !req_tvalid_o) break;
      tick();
    end
    chk("drained", {exp_q.size() == 0, req_tvalid_o}, 2'b10);
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 20; c++) begin
      if (req_tvalid_o) break;
      tick();
    end
    chk("wait_valid", req_tvalid_o, 1);
  endtask

  initial begin
    int beats, gaps, idx;
    exp_count = '0;
    stall_prev = 1'b0;
    saved = '0;
    cmd_addr_i = '0;
    cmd_data_i = '0;
    req_tready_i = 1'b0;
    do_reset();
    do_reset();

    // Reset state
    chk("rst_tvalid", req_tvalid_o, 0);
    chk("rst_tlast", req_tlast_o, 0);
    chk("rst_tid", req_tid_o, 0);
    chk("rst_tdata", req_tdata_o, 0);
    chk("rst_level", fifo_level_o, 0);
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_count", cmd_count_o, 0);

    // Single command latency and beat contents
    req_tready_i = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_addr_i = 19'h2A5F5;
    cmd_data_i = 16'hBEEF;
    tick();
    cmd_valid_i = 1'b0;
    chk("t1_c1_level", fifo_level_o, 1);
    chk("t1_c1_tvalid", req_tvalid_o, 0);
    tick();
    chk("t1_c2", {req_tvalid_o, req_tdata_o, req_tid_o, req_tlast_o}, {1'b1, 16'h54BE, 3'd5, 1'b0});
    tick();
    chk("t1_c3", {req_tvalid_o, req_tdata_o, req_tid_o, req_tlast_o}, {1'b1, 16'hBEEF, 3'd5, 1'b1});
    tick();
    chk("t1_c4_tvalid", req_tvalid_o, 0);
    chk("t1_c4_count", cmd_count_o, 1);

    // Back-to-back: 8 commands, 16 beats with no bubble
    do_reset();
    req_tready_i = 1'b1;
    idx = 0;
    beats = 0;
    gaps = 0;
    for (int c = 0; c < 60 && beats < 16; c++) begin
      cmd_valid_i = (idx < 8);
      cmd_addr_i = 19'($urandom);
      cmd_data_i = 16'($urandom);
      tick();
      if (last_acc) idx++;
      if (last_hs) begin
        chk("t2_tlast_parity", last_tlast, beats % 2);
        beats++;
      end else if (beats > 0) begin
        gaps++;
      end
    end
    cmd_valid_i = 1'b0;
    chk("t2_beats", beats, 16);
    chk("t2_gaps", gaps, 0);
    tick();
    chk("t2_count", cmd_count_o, 8);
    chk("t2_idle", req_tvalid_o, 0);

    // Backpressure on both beats; stability checked every stalled cycle
    do_reset();
    req_tready_i = 1'b0;
    send_n(1);
    wait_valid();
    for (int c = 0; c < 5; c++) tick();
    chk("t3_addr_hold", req_tlast_o, 0);
    req_tready_i = 1'b1;
    tick();
    req_tready_i = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk("t3_data_hold", {req_tvalid_o, req_tlast_o}, 2'b11);
    drain();
    chk("t3_count", cmd_count_o, 1);

    // FIFO full with DEPTH+2 commands offered
    do_reset();
    req_tready_i = 1'b0;
    send_n(DEPTH + 1);
    chk("t4_level", fifo_level_o, DEPTH);
    chk("t4_ready", cmd_ready_o, 0);
    cmd_valid_i = 1'b1;
    cmd_addr_i = 19'h7FFFF;
    cmd_data_i = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t4_stall", last_acc, 0);
    end
    req_tready_i = 1'b1;
    for (int c = 0; c < 10 && !last_acc; c++) tick();
    chk("t4_late_accept", last_acc, 1);
    drain();
    chk("t4_count", cmd_count_o, DEPTH + 2);

    // Reset during a data beat with 3 queued commands
    do_reset();
    req_tready_i = 1'b0;
    send_n(4);
    wait_valid();
    req_tready_i = 1'b1;
    tick();
    req_tready_i = 1'b0;
    chk("t5_pre", {req_tvalid_o, req_tlast_o, fifo_level_o}, {2'b11, 3'd3});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_post", {req_tvalid_o, fifo_level_o, cmd_count_o, cmd_ready_o}, {1'b0, 3'd0, 4'd0, 1'b1});
    req_tready_i = 1'b1;
    send_n(1);
    drain();
    chk("t5_count", cmd_count_o, 1);

    // Counter wrap: 17 commands on a 4-bit counter
    do_reset();
    req_tready_i = 1'b1;
    send_n(17);
    drain();
    chk("t6_wrap", cmd_count_o, 1);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      cmd_valid_i = 1'($urandom);
      cmd_addr_i = 19'($urandom);
      cmd_data_i = 16'($urandom);
      req_tready_i = ($urandom % 4) != 0;
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
